// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core memory back end: SRAM controller states,
// default data-segment base and DE2 SRAM geometry.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int DATA_BASE_DEFAULT = 1024;
  localparam int SRAM_DW           = 16;
  localparam int SRAM_AW           = 18;

endpackage

// File: rtl/sram_controller.sv
// 32-bit word access as two 16-bit SRAM phases; ready returns 2*(WAIT_CYCLES+1)+1 cycles after request.
// ready=0 freezes the pipeline; with SRAM_POSTED_WRITE_EN writes are posted and only a later request stalls.
module sram_controller
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  localparam int            CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  sram_state_t r_state;
  sram_state_t w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_wr;
  logic [16:0]        r_hw_addr;
  logic [31:0]        r_wdata;

  logic [31:0]        w_off;
  logic               w_req;
  logic               w_last;
  logic               w_drive;
  logic [SRAM_DW-1:0] w_dq_out;
  logic               w_unused_off;

  assign w_req        = wr_en | rd_en;
  assign w_off        = address - 32'(DATA_BASE);
  assign w_unused_off = ^{w_off[31:19], w_off[1:0]};
  assign w_last       = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req)  w_state_nxt = LOW;
      LOW:     if (w_last) w_state_nxt = HIGH;
      HIGH:    if (w_last) w_state_nxt = DONE;
      // DONE never re-arms: the pipeline advances on this edge with the old request still up.
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_hw_addr <= '0;
      r_wdata   <= '0;
      read_data <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == LOW || r_state == HIGH)
        r_cnt <= r_cnt + CW'(1);

      if (r_state == IDLE && w_req) begin
        r_wr      <= wr_en;
        r_hw_addr <= w_off[18:2];
        r_wdata   <= write_data;
      end

      if (!r_wr && w_last) begin
        if (r_state == LOW)
          read_data[15:0] <= SRAM_DQ;
        else if (r_state == HIGH)
          read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    w_drive   = 1'b0;
    w_dq_out  = '0;
    if (r_state == LOW || r_state == HIGH) begin
      SRAM_ADDR = {r_hw_addr, (r_state == HIGH)};
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      SRAM_CE_N = 1'b0;
      if (r_wr) begin
        SRAM_WE_N = 1'b0;
        w_drive   = 1'b1;
        w_dq_out  = (r_state == LOW) ? r_wdata[15:0] : r_wdata[31:16];
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ = w_drive ? w_dq_out : {SRAM_DW{1'bz}};

`ifdef SRAM_POSTED_WRITE_EN
  // A busy posted write only stalls a requester that actually asks for the SRAM.
  always_comb begin
    ready = 1'b1;
    case (r_state)
      IDLE:    ready = wr_en | ~rd_en;
      LOW:     ready = r_wr ? ~w_req : 1'b0;
      HIGH:    ready = r_wr ? ~w_req : 1'b0;
      DONE:    ready = r_wr ? ~w_req : 1'b1;
      default: ready = 1'b1;
    endcase
  end
`else
  always_comb begin
    ready = 1'b1;
    case (r_state)
      IDLE:    ready = ~w_req;
      LOW:     ready = 1'b0;
      HIGH:    ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end
`endif

endmodule
